xor_skolem_stream: RTL and testbench
====================================

// Module: xor_skolem_stream
// PURPOSE
//   Pipelined, parametrised parity Skolem evaluator. Each frame is one or more
//   WIDTH-bit beats; the block emits the XOR (or XNOR) of every bit in the frame.
//   A one-beat frame with WIDTH=6 and in_invert=1 is i6 = ~(i0^i1^...^i5).
//   It sits between the assignment generator and the Skolem-check scoreboard.
//   Valid/ready on both sides, backpressure supported.
// PARAMETERS
//   WIDTH   6   input bits per beat (>=1)
//   CHUNK   8   leaf size of the XOR reduction tree (>=2)
//   BEAT_W  8   width of the per-frame beat counter (saturating)
// PORTS
//   clk        in   1       single clock, rising edge
//   rst        in   1       asynchronous, active-high reset
//   in_data    in   WIDTH   assignment bits i0..i(WIDTH-1) of this beat
//   in_valid   in   1       beat offered
//   in_last    in   1       beat closes the frame
//   in_invert  in   1       0: XOR result, 1: XNOR result (used on last beat only)
//   in_ready   out  1       beat accepted when in_valid & in_ready
//   out_bit    out  1       frame parity result
//   out_beats  out  BEAT_W  beats in the frame, saturating at 2^BEAT_W-1
//   out_valid  out  1       result valid; held with stable data until out_ready
//   out_ready  in   1       consumer accepts result
// BEHAVIOUR
//   - Reset, async assert: all valids=0, accumulator=0, beat count=0,
//     out_bit=0, out_beats=0. Reset release is synchronous to clk.
//   - Two register stages. No pipeline flush on a frame boundary.
//     S1 registers the beat: p = ^in_data, computed by the CHUNK tree; also
//     last, invert, valid.
//     S2 holds the accumulator: acc ^= p and cnt = sat(cnt+1) on each S1
//     beat. On an S1 beat with last=1 it loads:
//       out_bit   = acc ^ p ^ invert
//       out_beats = sat(cnt+1)
//       out_valid = 1
//     It also clears acc and cnt for the next frame.
//   - Latency: the last-beat handshake in cycle t gives out_valid at t+2,
//     with no stall.
//   - Throughput: 1 beat/cycle. Back-to-back frames are allowed, including
//     one-beat frames every cycle.
//   - Stall: stall = out_valid & ~out_ready.
//     in_ready = ~stall (combinational from out_ready).
//     While stalled, S1 and S2 hold their contents, including acc and cnt.
//   - Handshake rule: out_bit and out_beats must not change while
//     out_valid=1 & out_ready=0.
//   - Handshake rule: in_data is ignored when in_valid=0.
//   - Simultaneous events, same cycle: accept the new last beat into S1,
//     S2 emits the previous frame, and the consumer takes the old result.
//     This must work with no bubble.
//   - Saturation: cnt stops at 2^BEAT_W-1. Parity keeps accumulating.
//   - Reset mid-frame discards the partial frame. The first beat after reset
//     starts a new frame.
//   - in_invert on non-last beats: ignored.
// STRUCTURE
//   - Package xor_skolem_pkg:
//       localparams MODE_XOR=1'b0, MODE_XNOR=1'b1
//       function clog2-based leaf-count helper
//       typedef s1_t {p, last, invert}
//   - Sub-module xor_reduce_tree #(WIDTH, CHUNK): combinational.
//       Leaf XORs over CHUNK-bit slices, then a fold of the leaf results.
//       Zero-pads the last slice.
//   - Top holds S1/S2 registers, stall logic and the saturating counter.
// TESTING
//   1. WIDTH=6, one beat 6'b000001, last=1, invert=1
//      -> out_bit=0, out_beats=1, out_valid 2 cycles after accept.
//   2. One beat 6'b000000, invert=1 -> out_bit=1. Sweep all 64 patterns
//      -> out_bit == ~^in_data every time.
//   3. 3-beat frame 6'b000011, 6'b000001, 6'b100000 (last), invert=0
//      -> out_bit=0, out_beats=3.
//   4. Hold out_ready=0 for 5 cycles while 4 one-beat frames are offered
//      -> in_ready=0 after stall, no result lost or duplicated, results in
//      order, out_bit stable.
//   5. Assert rst mid-frame after 2 beats, then a 1-beat frame 6'b000111,
//      invert=0 -> out_bit=1, out_beats=1. No stale parity.
//   6. BEAT_W=2, 5-beat frame -> out_beats=3 (saturated), parity correct.

Source files
------------

// File: rtl/xor_skolem_pkg.sv
// Shared types and helpers for the frame-parity Skolem evaluator.
package xor_skolem_pkg;

  // Result polarity selected by in_invert on the closing beat of a frame.
  localparam logic MODE_XOR  = 1'b0;
  localparam logic MODE_XNOR = 1'b1;

  // Number of leaves in the reduction tree: enough CHUNK-wide slices to
  // cover WIDTH bits, rounded up to a power of two so the fold is balanced.
  function automatic int leaf_count(input int width, input int chunk);
    int raw;
    raw = (width + chunk - 1) / chunk;
    return 1 << $clog2(raw);
  endfunction

  // Contents of the first pipeline stage for one accepted beat.
  typedef struct packed {
    logic p;       // parity of the beat's data bits
    logic last;    // beat closes the frame
    logic invert;  // polarity request, only meaningful when last=1
  } s1_t;

endpackage

// File: rtl/xor_reduce_tree.sv
// Combinational XOR reduction: per-slice leaf XORs followed by a balanced
// fold of the leaf results. The top slice and any spare leaves are zero-padded,
// which leaves the parity unchanged.
module xor_reduce_tree
  import xor_skolem_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int CHUNK = 8
) (
  input  logic [WIDTH-1:0] data,
  output logic             parity
);

  localparam int NL = leaf_count(WIDTH, CHUNK);
  localparam int PW = NL * CHUNK;

  logic [PW-1:0] padded;
  logic [NL-1:0] leaf;
  logic [NL-1:0] fold;

  // Widen the input to a whole number of leaves.
  always_comb begin
    padded = '0;
    padded[WIDTH-1:0] = data;
  end

  for (genvar g = 0; g < NL; g++) begin : g_leaf
    assign leaf[g] = ^padded[g*CHUNK +: CHUNK];
  end

  // Pairwise fold, halving the live leaf count each level.
  // Writing index i only ever overwrites entries already consumed at this level.
  always_comb begin
    fold = leaf;
    for (int s = NL / 2; s >= 1; s = s / 2) begin
      for (int i = 0; i < s; i++) begin
        fold[i] = fold[2*i] ^ fold[2*i+1];
      end
    end
    parity = fold[0];
  end

endmodule

// File: rtl/xor_skolem_stream.sv
// Streaming frame-parity evaluator. Stage 1 registers the parity of each
// accepted beat; stage 2 accumulates parity and beat count across the frame
// and presents the result with valid/ready. Both stages freeze together while
// the consumer stalls, so in_ready is simply the inverse of that stall.
module xor_skolem_stream
  import xor_skolem_pkg::*;
#(
  parameter int WIDTH  = 6,
  parameter int CHUNK  = 8,
  parameter int BEAT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_valid,
  input  logic              in_last,
  input  logic              in_invert,
  output logic              in_ready,
  output logic              out_bit,
  output logic [BEAT_W-1:0] out_beats,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam logic [BEAT_W-1:0] CNT_MAX = '1;
  localparam logic [BEAT_W-1:0] CNT_ONE = 1;

  logic              stall;
  logic              beat_p;
  s1_t               s1_q;
  logic              s1_valid_q;
  logic              acc_q;
  logic [BEAT_W-1:0] cnt_q;
  logic [BEAT_W-1:0] cnt_inc;

  xor_reduce_tree #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK)
  ) u_tree (
    .data   (in_data),
    .parity (beat_p)
  );

  // A held result blocks the whole pipe; a result being taken this cycle
  // frees it, so a new beat can enter while the old result leaves.
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // Beat counter increment that sticks at all-ones.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

  // Stage 1: capture the beat's parity and framing flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else if (!stall) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_q <= '{p: beat_p, last: in_last, invert: in_invert};
      end
    end
  end

  // Stage 2: accumulate across the frame and publish on the closing beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= 1'b0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      out_beats <= '0;
    end else if (!stall) begin
      out_valid <= s1_valid_q & s1_q.last;
      if (s1_valid_q) begin
        if (s1_q.last) begin
          out_bit   <= acc_q ^ s1_q.p ^ (s1_q.invert == MODE_XNOR);
          out_beats <= cnt_inc;
          acc_q     <= 1'b0;
          cnt_q     <= '0;
        end else begin
          acc_q <= acc_q ^ s1_q.p;
          cnt_q <= cnt_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_xor_skolem_stream.sv
// Directed bench for xor_skolem_stream. A second instance with BEAT_W=2
// shares every input so the saturating counter can be checked on the same
// traffic.
module tb_xor_skolem_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_invert;
  logic       out_ready;

  logic       in_ready;
  logic       out_bit;
  logic [7:0] out_beats;
  logic       out_valid;

  logic       in_ready_s;
  logic       out_bit_s;
  logic [1:0] out_beats_s;
  logic       out_valid_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  xor_skolem_stream #(.WIDTH(6), .CHUNK(8), .BEAT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_invert (in_invert),
    .in_ready  (in_ready),
    .out_bit   (out_bit),
    .out_beats (out_beats),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  xor_skolem_stream #(.WIDTH(6), .CHUNK(4), .BEAT_W(2)) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_invert (in_invert),
    .in_ready  (in_ready_s),
    .out_bit   (out_bit_s),
    .out_beats (out_beats_s),
    .out_valid (out_valid_s),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    total++;
    bad++;
    $display("FAIL %s: observed=timeout expected=event", tag);
  endtask

  // Offer one beat and hold it until accepted; data is scrambled afterwards.
  task automatic send(input logic [5:0] d, input logic l, input logic inv);
    int n;
    n = 0;
    in_data   = d;
    in_valid  = 1'b1;
    in_last   = l;
    in_invert = inv;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) timeout_fail("send_ready");
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_data   = 6'b101101;
    in_last   = 1'b1;
    in_invert = 1'b1;
  endtask

  // Wait for a result, check it, then let it be consumed (out_ready=1).
  task automatic get_result(input string tag, input logic eb, input logic [7:0] ebeats);
    int n;
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) timeout_fail({tag, "_valid"});
    else begin
      check({tag, "_bit"}, out_bit, eb);
      check({tag, "_beats"}, out_beats, ebeats);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] fd [4];
    logic       fv [4];
    logic       fexp [4];
    logic [5:0] v;
    int         fi;
    int         rxn;
    logic       saw_block;
    logic       took;

    rst       = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_invert = 1'b0;
    out_ready = 1'b1;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_bit", out_bit, 0);
    check("rst_out_beats", out_beats, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: single beat, XNOR, two-cycle latency
    send(6'b000001, 1'b1, 1'b1);
    check("t1_no_valid_at_t1", out_valid, 0);
    @(posedge clk); #1;
    check("t1_valid_at_t2", out_valid, 1);
    get_result("t1", 1'b0, 8'd1);

    // 2: all-zero beat then sweep of every pattern with XNOR
    send(6'b000000, 1'b1, 1'b1);
    get_result("t2_zero", 1'b1, 8'd1);
    for (int i = 0; i < 64; i++) begin
      v = 6'(i);
      send(v, 1'b1, 1'b1);
      get_result($sformatf("t2_sweep_%0d", i), ~^v, 8'd1);
    end

    // 3: three-beat XOR frame
    send(6'b000011, 1'b0, 1'b1);
    send(6'b000001, 1'b0, 1'b1);
    send(6'b100000, 1'b1, 1'b0);
    get_result("t3", 1'b0, 8'd3);

    // 4: consumer stalls for 5 cycles while four one-beat frames are offered
    fd[0] = 6'b000001; fv[0] = 1'b0; fexp[0] = 1'b1;
    fd[1] = 6'b000011; fv[1] = 1'b0; fexp[1] = 1'b0;
    fd[2] = 6'b000111; fv[2] = 1'b1; fexp[2] = 1'b0;
    fd[3] = 6'b001111; fv[3] = 1'b1; fexp[3] = 1'b1;
    fi = 0;
    rxn = 0;
    saw_block = 1'b0;
    for (int c = 0; c < 20; c++) begin
      out_ready = (c >= 5);
      if (fi < 4) begin
        in_valid  = 1'b1;
        in_data   = fd[fi];
        in_last   = 1'b1;
        in_invert = fv[fi];
      end else begin
        in_valid = 1'b0;
        in_data  = 6'b110011;
      end
      #1;
      if (out_valid && rxn < 4) begin
        check($sformatf("t4_bit_%0d_c%0d", rxn, c), out_bit, fexp[rxn]);
        check($sformatf("t4_beats_%0d_c%0d", rxn, c), out_beats, 1);
      end
      if (out_valid && !out_ready) begin
        check($sformatf("t4_in_ready_stall_c%0d", c), in_ready, 0);
        saw_block = 1'b1;
      end
      if (out_valid && out_ready) rxn++;
      took = in_valid && in_ready;
      @(posedge clk); #1;
      if (took) fi++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("t4_results_count", rxn, 4);
    check("t4_frames_accepted", fi, 4);
    check("t4_stall_seen", saw_block, 1);

    // 5: reset in the middle of a frame holding odd partial parity
    send(6'b000001, 1'b0, 1'b0);
    send(6'b000000, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("t5_rst_out_valid", out_valid, 0);
    check("t5_rst_out_bit", out_bit, 0);
    check("t5_rst_out_beats", out_beats, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    send(6'b000111, 1'b1, 1'b0);
    get_result("t5", 1'b1, 8'd1);

    // 6: five-beat frame, parity 1, narrow counter saturates at 3
    send(6'b000001, 1'b0, 1'b0);
    send(6'b000011, 1'b0, 1'b0);
    send(6'b000111, 1'b0, 1'b0);
    send(6'b001111, 1'b0, 1'b0);
    send(6'b011111, 1'b1, 1'b0);
    @(posedge clk); #1;
    check("t6_valid", out_valid, 1);
    check("t6_bit", out_bit, 1);
    check("t6_beats_wide", out_beats, 5);
    check("t6_sat_valid", out_valid_s, 1);
    check("t6_sat_bit", out_bit_s, 1);
    check("t6_sat_beats", out_beats_s, 3);
    @(posedge clk); #1;
    check("t6_consumed", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
